// File: rtl/aes_ks_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher key-schedule sequencer.
package aes_ks_pkg;

    localparam int NR_DEF  = 10;
    localparam int RKW_DEF = 128;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KLD    = 2'd1,
        EXPAND = 2'd2
    } ks_state_t;

endpackage

// File: rtl/aes_rk_buf.sv
// Round-key buffer: NR+1 entries, one synchronous write port, one registered read port.
module aes_rk_buf
    import aes_ks_pkg::*;
#(
    parameter int NR  = NR_DEF,
    parameter int RKW = RKW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [RKW-1:0]   wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [RKW-1:0]   rdata,
    output logic             rvld
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

    // Storage is deliberately not reset; it is unreachable until a full schedule lands.
    logic [RKW-1:0] mem [NR+1];

    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST)) begin
            mem[waddr] <= wdata;
        end
    end

    // Indices past the last round read back as zero rather than aliasing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rvld  <= 1'b0;
        end else begin
            rvld <= re;
            if (re) begin
                rdata <= (raddr <= LAST) ? mem[raddr] : '0;
            end
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Key-load sequencer: strobes the expander, captures NR+1 round keys, then serves reads.
module aes_key_sched_ctrl
    import aes_ks_pkg::*;
#(
    parameter int NR  = NR_DEF,
    parameter int RKW = RKW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    output logic             exp_kld,
    input  logic [RKW-1:0]   rk_in,
    input  logic             rd,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [RKW-1:0]   rk_out,
    output logic             rk_vld,
    output logic             busy,
    output logic             key_valid,
    output ks_state_t        state_dbg
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

    ks_state_t        state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic             kv_nxt;
    logic             buf_we;
    logic             rd_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_valid <= kv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        kv_nxt    = key_valid;
        exp_kld   = 1'b0;
        busy      = 1'b0;
        buf_we    = 1'b0;
        case (state)
            IDLE: begin
                if (ld) begin
                    state_nxt = KLD;
                    kv_nxt    = 1'b0;
                end
            end
            KLD: begin
                exp_kld   = 1'b1;
                busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = EXPAND;
            end
            EXPAND: begin
                busy   = 1'b1;
                buf_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    kv_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A new load request always restarts the sequence, whatever the current state.
        if (ld) begin
            state_nxt = KLD;
            cnt_nxt   = '0;
            kv_nxt    = 1'b0;
        end
    end

    // Read protocol: rd is sampled with rd_idx; an accepted read yields rk_vld for exactly
    // one cycle with rk_out; no backpressure, one read per cycle, ld in the same cycle drops it.
    assign rd_accept = rd && key_valid && !ld;
    assign state_dbg = state;

    aes_rk_buf #(
        .NR  (NR),
        .RKW (RKW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (cnt),
        .wdata (rk_in),
        .re    (rd_accept),
        .raddr (rd_idx),
        .rdata (rk_out),
        .rvld  (rk_vld)
    );

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer for the AES-128 key-expansion datapath used by the inverse cipher. On a key-load request it pulses the expander's load strobe, captures the NR+1 round keys the expander produces on consecutive cycles into an internal round-key buffer, then serves random-access round-key reads, typically round NR down to 0, to the inverse-cipher round logic. It sits between the top-level key-load interface and the expander/rcon pair, and owns their start and step timing.

## Interface
- NR, 10: number of AES rounds. The buffer holds NR+1 round keys.
- RKW, 128: round-key width in bits.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  key-load request, sampled high for one cycle. The expander already holds the key.
- exp_kld  out  1  one-cycle load strobe to the key expander and rcon generator.
- rk_in  in  RKW  round key from the expander. Round r is valid at cycle exp_kld+1+r.
- rd  in  1  round-key read request.
- rd_idx  in  4  round index to read, 0..NR.
- rk_out  out  RKW  registered read data.
- rk_vld  out  1  one-cycle pulse when rk_out is updated.
- busy  out  1  expansion in progress.
- key_valid  out  1  buffer holds a complete schedule for the last accepted key.

## Operation
- The FSM has three states: IDLE, KLD and EXPAND. The reset state is IDLE.
- IDLE:
  - ld=1 leads to KLD.
  - key_valid is cleared in the same edge.
- KLD lasts exactly one cycle:
  - exp_kld=1 and busy=1.
  - The capture counter cnt is cleared to 0.
  - The next state is always EXPAND.
- EXPAND:
  - Each cycle, rk_in is written to buffer[cnt] and cnt is incremented.
  - When cnt==NR is written, the state returns to IDLE and key_valid is set.
- ld in KLD or EXPAND aborts and restarts:
  - The next state is KLD.
  - cnt is reloaded.
  - key_valid stays 0.
  - Partially written entries are don't-care.
- ld while key_valid=1: key_valid drops on the next edge and the sequence restarts.
- Reads:
  - A read is accepted only when key_valid=1, ld=0 and rd=1.
  - An accepted read with rd_idx<=NR gives rk_out=buffer[rd_idx] and rk_vld=1 on the next edge.
  - An accepted read with rd_idx>NR gives rk_out=0 and rk_vld=1.
  - A read that is not accepted leaves rk_out unchanged and gives rk_vld=0.
- ld and rd in the same cycle: ld wins and the read is dropped.
- cnt width is 4 bits. cnt never exceeds NR, so it never wraps.
- Reset values:
  - exp_kld, busy, key_valid, rk_vld and rk_out are all 0.
  - cnt is 0 and the state is IDLE.
  - Buffer contents are not cleared. They are unreachable until key_valid=1.
- Reset mid-expansion forces IDLE and key_valid=0 on that edge. The expander is not re-strobed until a new ld.

## Timing
- ld sampled at edge t:
  - exp_kld is high during cycle t+1.
  - busy is high for cycles t+1 .. t+NR+2.
  - rk_in is captured at the edges ending cycles t+2 .. t+NR+2, round 0 first.
  - key_valid goes high from cycle t+NR+3. For NR=10 that is 13 cycles after ld.
- Read latency is 1 cycle: rd sampled at edge u gives rk_out/rk_vld valid in cycle u+1.
- Back-to-back reads are sustained at one per cycle.
- busy and key_valid are never both 1.

## Structure
- The package aes_ks_pkg holds:
  - the state enum (IDLE, KLD, EXPAND);
  - the NR default;
  - the index-width constant (4);
  - the RKW default.
- Sub-module aes_rk_buf provides:
  - NR+1 entries of RKW bits;
  - one synchronous write port (we, waddr, wdata);
  - one registered read port with an out-of-range-returns-zero rule.
- The FSM and cnt live in aes_key_sched_ctrl.

## Test plan
- Reset, then ld at cycle 5, with rk_in = 128'h{r repeated} for round r:
  - exp_kld is high only in cycle 6.
  - busy is high in cycles 6-17.
  - key_valid is high from cycle 18.
- After a full load, read rd_idx=10,9,...,0 back-to-back:
  - rk_out matches rounds 10..0 in order, one per cycle.
  - rk_vld stays high for 11 cycles.
- Assert ld again 4 cycles into EXPAND:
  - exp_kld re-pulses on the next cycle.
  - key_valid rises exactly 13 cycles after the second ld.
  - The buffer contents match the second key stream only.
- rd during busy, and rd together with ld:
  - rk_vld stays 0 and rk_out is unchanged.
- rd_idx=11 and rd_idx=15 with key_valid=1:
  - rk_out=0 and rk_vld=1.
- rst asserted mid-EXPAND, at cnt=6:
  - Next cycle shows IDLE with busy=0, key_valid=0 and exp_kld=0.
  - A subsequent ld completes a normal 13-cycle load.
